spikes_tmpram_reader: RTL and testbench

//  Read-side counterpart of the line packer/TmpRam writer. Fetches packed spike lines
//  (IMG_WIDTH pixels x TIME_STEPS bits) from a SpikesTmpRam read port and unpacks them

---
 rtl/spikes_tmpram_reader.sv | 214 +++++++++++++++++++++
 tb/tb_spikes_tmpram_reader.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spikes_tmpram_reader.sv
// spikes_tmpram_reader
// Fetches packed spike lines (IMG_WIDTH pixels x TIME_STEPS bits) from a SpikesTmpRam
// read port into a two-line buffer and streams them out one pixel per valid/ready beat,
// first pixel taken from the line MSBs. A single-cycle done pulse closes each frame.
// Optional feature macro: SPIKES_READER_CNT_EN adds o_spike_cnt, a saturating count of
// the 1-bits in every transferred beat.
module spikes_tmpram_reader #(
    parameter int TIME_STEPS = 4,
    parameter int IMG_WIDTH  = 32,
    parameter int ADDR_W     = 13,
    parameter int READ_LAT   = 2
) (
    input  logic                            s_clk,
    input  logic                            s_rst,
    input  logic                            i_start,
    input  logic [ADDR_W-1:0]               i_base_addr,
    input  logic [ADDR_W-1:0]               i_line_num,
    output logic                            o_busy,
    output logic [ADDR_W-1:0]               o_ram_addrb,
    input  logic [IMG_WIDTH*TIME_STEPS-1:0] i_ram_doutb,
    output logic                            o_spikes_valid,
    output logic [TIME_STEPS-1:0]           o_spikes,
    input  logic                            i_spikes_ready,
    output logic                            o_spikes_done
`ifdef SPIKES_READER_CNT_EN
    ,
    output logic [31:0]                     o_spike_cnt
`endif
);

    localparam int LINE_W = IMG_WIDTH * TIME_STEPS;
    localparam int BEAT_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(IMG_WIDTH - 1);
    localparam logic [BEAT_W-1:0] ONE_B     = BEAT_W'(1);
    localparam logic [ADDR_W-1:0] ONE_A     = ADDR_W'(1);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    state_t                state_q, state_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [ADDR_W-1:0]     fetch_left_q, fetch_left_d;
    logic [ADDR_W-1:0]     stream_left_q, stream_left_d;
    logic [READ_LAT:0]     pend_q, pend_d;
    logic [LINE_W-1:0]     line_q [2];
    logic [LINE_W-1:0]     line_d [2];
    logic [1:0]            full_q, full_d;
    logic                  wr_sel_q, wr_sel_d;
    logic                  rd_sel_q, rd_sel_d;
    logic [BEAT_W-1:0]     beat_q, beat_d;

    logic                  capture;
    logic                  spikes_valid;
    logic                  xfer;
    logic                  start_accept;
    logic [1:0]            occupancy;
    logic [BEAT_W-1:0]     pix_idx;

    assign capture      = pend_q[READ_LAT];
    assign spikes_valid = full_q[rd_sel_q];
    assign xfer         = spikes_valid & i_spikes_ready;
    assign start_accept = (state_q == ST_IDLE) & i_start;
    assign occupancy    = {1'b0, full_q[0]} + {1'b0, full_q[1]} + {1'b0, capture};
    assign pix_idx      = LAST_BEAT - beat_q;

    assign o_busy         = busy_q;
    assign o_ram_addrb    = addr_q;
    assign o_spikes_done  = done_q;
    assign o_spikes_valid = spikes_valid;
    assign o_spikes       = spikes_valid ? line_q[rd_sel_q][pix_idx*TIME_STEPS +: TIME_STEPS]
                                         : '0;

    // Next-state logic: frame FSM, single-outstanding fetch engine, line capture and unpacking.
    always_comb begin
        state_d       = state_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        addr_d        = addr_q;
        fetch_left_d  = fetch_left_q;
        stream_left_d = stream_left_q;
        pend_d        = {pend_q[READ_LAT-1:0], 1'b0};
        line_d        = line_q;
        full_d        = full_q;
        wr_sel_d      = wr_sel_q;
        rd_sel_d      = rd_sel_q;
        beat_d        = beat_q;
        unique case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    if (i_line_num == '0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d       = ST_RUN;
                        busy_d        = 1'b1;
                        addr_d        = i_base_addr;
                        fetch_left_d  = i_line_num - ONE_A;
                        stream_left_d = i_line_num;
                        pend_d[0]     = 1'b1;
                        full_d        = '0;
                        wr_sel_d      = 1'b0;
                        rd_sel_d      = 1'b0;
                        beat_d        = '0;
                    end
                end
            end
            ST_RUN: begin
                if (capture) begin
                    line_d[wr_sel_q] = i_ram_doutb;
                    full_d[wr_sel_q] = 1'b1;
                    wr_sel_d         = ~wr_sel_q;
                end
                if (xfer) begin
                    if (beat_q == LAST_BEAT) begin
                        beat_d           = '0;
                        full_d[rd_sel_q] = 1'b0;
                        rd_sel_d         = ~rd_sel_q;
                        stream_left_d    = stream_left_q - ONE_A;
                        if (stream_left_q == ONE_A) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                        end
                    end else begin
                        beat_d = beat_q + ONE_B;
                    end
                end
                if ((fetch_left_q != '0) && (pend_q[READ_LAT-1:0] == '0) && (occupancy < 2'd2)) begin
                    addr_d       = addr_q + ONE_A;
                    fetch_left_d = fetch_left_q - ONE_A;
                    pend_d[0]    = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; synchronous reset aborts any frame in progress.
    always_ff @(posedge s_clk) begin
        if (s_rst) begin
            state_q       <= ST_IDLE;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            addr_q        <= '0;
            fetch_left_q  <= '0;
            stream_left_q <= '0;
            pend_q        <= '0;
            line_q[0]     <= '0;
            line_q[1]     <= '0;
            full_q        <= '0;
            wr_sel_q      <= 1'b0;
            rd_sel_q      <= 1'b0;
            beat_q        <= '0;
        end else begin
            state_q       <= state_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            addr_q        <= addr_d;
            fetch_left_q  <= fetch_left_d;
            stream_left_q <= stream_left_d;
            pend_q        <= pend_d;
            line_q[0]     <= line_d[0];
            line_q[1]     <= line_d[1];
            full_q        <= full_d;
            wr_sel_q      <= wr_sel_d;
            rd_sel_q      <= rd_sel_d;
            beat_q        <= beat_d;
        end
    end

`ifdef SPIKES_READER_CNT_EN
    localparam int POP_W = $clog2(TIME_STEPS + 1);

    logic [31:0]      cnt_q, cnt_d;
    logic [POP_W-1:0] pop;
    logic [32:0]      cnt_sum;

    assign o_spike_cnt = cnt_q;

    // Spike counter: popcount of each transferred beat, saturating, cleared on start.
    always_comb begin
        pop = '0;
        for (int i = 0; i < TIME_STEPS; i++) begin
            pop = pop + POP_W'(o_spikes[i]);
        end
        cnt_sum = {1'b0, cnt_q} + 33'(pop);
        cnt_d   = cnt_q;
        if (start_accept) begin
            cnt_d = '0;
        end else if (xfer) begin
            cnt_d = cnt_sum[32] ? 32'hFFFF_FFFF : cnt_sum[31:0];
        end
    end

    // Spike counter register.
    always_ff @(posedge s_clk) begin
        if (s_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_start_accept;
    assign unused_start_accept = start_accept;
`endif

endmodule

// File: tb/tb_spikes_tmpram_reader.sv
// Testbench for spikes_tmpram_reader: a two-stage RAM model feeds the reader, and each
// scenario task compares the observed beat stream, addresses and timing against a
// reference built directly from RAM contents.
module tb_spikes_tmpram_reader;

    localparam int TS = 4;
    localparam int IW = 32;
    localparam int AW = 13;
    localparam int RL = 2;
    localparam int LW = IW * TS;

    logic          s_clk = 1'b0;
    logic          s_rst;
    logic          i_start;
    logic [AW-1:0] i_base_addr;
    logic [AW-1:0] i_line_num;
    logic          o_busy;
    logic [AW-1:0] o_ram_addrb;
    logic [LW-1:0] i_ram_doutb;
    logic          o_spikes_valid;
    logic [TS-1:0] o_spikes;
    logic          i_spikes_ready;
    logic          o_spikes_done;
`ifdef SPIKES_READER_CNT_EN
    logic [31:0]   o_spike_cnt;
`endif

    int checks = 0;
    int errors = 0;

    bit   [LW-1:0] mem [0:8191];
    logic [LW-1:0] ram_stage;

    logic [TS-1:0] got_beats [$];
    int            got_cyc   [$];
    int            got_addrs [$];
    int            done_cyc  [$];
    logic [TS-1:0] exp_beats [$];
    int            exp_addrs [$];
    int            valid_seen;
    int            stall_err;
    bit            timed_out;
    logic [4+AW+TS-1:0] post_rst;

    spikes_tmpram_reader #(
        .TIME_STEPS(TS), .IMG_WIDTH(IW), .ADDR_W(AW), .READ_LAT(RL)
    ) dut (
        .s_clk          (s_clk),
        .s_rst          (s_rst),
        .i_start        (i_start),
        .i_base_addr    (i_base_addr),
        .i_line_num     (i_line_num),
        .o_busy         (o_busy),
        .o_ram_addrb    (o_ram_addrb),
        .i_ram_doutb    (i_ram_doutb),
        .o_spikes_valid (o_spikes_valid),
        .o_spikes       (o_spikes),
        .i_spikes_ready (i_spikes_ready),
        .o_spikes_done  (o_spikes_done)
`ifdef SPIKES_READER_CNT_EN
        ,
        .o_spike_cnt    (o_spike_cnt)
`endif
    );

    always #5 s_clk = ~s_clk;

    // RAM model: address registered into the array, then one output register.
    always @(posedge s_clk) begin
        ram_stage   <= mem[o_ram_addrb];
        i_ram_doutb <= ram_stage;
    end

    task automatic build_expected(input int base, input int lines);
        logic [LW-1:0] line;
        exp_beats.delete();
        exp_addrs.delete();
        for (int l = 0; l < lines; l++) begin
            exp_addrs.push_back((base + l) % 8192);
            line = mem[(base + l) % 8192];
            for (int k = 0; k < IW; k++) begin
                exp_beats.push_back(line[(IW - 1 - k) * TS +: TS]);
            end
        end
    endtask

    task automatic fill_random(input int base, input int lines);
        for (int l = 0; l < lines; l++) begin
            mem[(base + l) % 8192] = {$urandom, $urandom, $urandom, $urandom};
        end
    endtask

    task automatic run_frame(input int base, input int lines, input bit rand_ready,
                             input int extra_rel, input int abort_beat);
        bit            prev_stall;
        logic [TS-1:0] prev_spk;
        int            budget;
        int            done_rel;
        got_beats.delete();
        got_cyc.delete();
        got_addrs.delete();
        done_cyc.delete();
        valid_seen = 0;
        stall_err  = 0;
        timed_out  = 1'b0;
        prev_stall = 1'b0;
        prev_spk   = '0;
        done_rel   = -1;
        budget     = lines * IW * 4 + 40;
        @(posedge s_clk); #1;
        i_start        = 1'b1;
        i_base_addr    = AW'(base);
        i_line_num     = AW'(lines);
        i_spikes_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        for (int rel = 0; rel < budget; rel++) begin
            @(negedge s_clk);
            if (prev_stall && (o_spikes_valid !== 1'b1 || o_spikes !== prev_spk)) stall_err++;
            prev_stall = o_spikes_valid && !i_spikes_ready;
            prev_spk   = o_spikes;
            if (o_spikes_valid) valid_seen++;
            if (o_spikes_valid && i_spikes_ready) begin
                got_beats.push_back(o_spikes);
                got_cyc.push_back(rel);
            end
            if (o_busy && (got_addrs.size() == 0 || got_addrs[$] != int'(o_ram_addrb)))
                got_addrs.push_back(int'(o_ram_addrb));
            if (o_spikes_done) begin
                done_cyc.push_back(rel);
                if (done_rel < 0) done_rel = rel;
            end
            if (done_rel >= 0 && rel >= done_rel + 3) break;
            if (abort_beat >= 0 && got_beats.size() == abort_beat) begin
                @(posedge s_clk); #1;
                i_start = 1'b0;
                s_rst   = 1'b1;
                @(posedge s_clk); #1;
                s_rst = 1'b0;
                @(negedge s_clk);
                post_rst = {o_busy, o_spikes_valid, o_spikes_done, 1'b0, o_ram_addrb, o_spikes};
                for (int j = 0; j < 12; j++) begin
                    if (o_spikes_done) done_cyc.push_back(j);
                    @(negedge s_clk);
                end
                break;
            end
            @(posedge s_clk); #1;
            i_start = (rel + 1 == extra_rel);
            if (i_start) begin
                i_base_addr = AW'(500);
                i_line_num  = AW'(5);
            end
            if (rand_ready) i_spikes_ready = 1'($urandom_range(0, 1));
        end
        if (done_rel < 0 && abort_beat < 0) timed_out = 1'b1;
        i_start        = 1'b0;
        i_spikes_ready = 1'b1;
    endtask

    task automatic test_reset();
        s_rst          = 1'b1;
        i_start        = 1'b0;
        i_base_addr    = '0;
        i_line_num     = '0;
        i_spikes_ready = 1'b0;
        repeat (3) @(posedge s_clk);
        #1 s_rst = 1'b0;
        @(negedge s_clk);
        checks += 5;
        if (o_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset busy: got %b expected 0", o_busy); end
        if (o_spikes_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset valid: got %b expected 0", o_spikes_valid); end
        if (o_spikes !== '0) begin errors++; $display("[TB] FAIL reset spikes: got %h expected 0", o_spikes); end
        if (o_spikes_done !== 1'b0) begin errors++; $display("[TB] FAIL reset done: got %b expected 0", o_spikes_done); end
        if (o_ram_addrb !== '0) begin errors++; $display("[TB] FAIL reset addr: got %0d expected 0", o_ram_addrb); end
`ifdef SPIKES_READER_CNT_EN
        checks++;
        if (o_spike_cnt !== 32'd0) begin errors++; $display("[TB] FAIL reset cnt: got %0d expected 0", o_spike_cnt); end
`endif
    endtask

    task automatic test_single_line();
        logic [LW-1:0] pattern;
        pattern = 128'h0123456789ABCDEF_0123456789ABCDEF;
        mem[0] = pattern;
        build_expected(0, 1);
        run_frame(0, 1, 1'b0, -1, -1);
        checks++;
        if (got_beats.size() != 32) begin errors++; $display("[TB] FAIL t1 beat count: got %0d expected 32", got_beats.size()); end
        for (int i = 0; i < exp_beats.size() && i < got_beats.size(); i++) begin
            checks++;
            if (got_beats[i] !== exp_beats[i]) begin errors++; $display("[TB] FAIL t1 beat %0d: got %h expected %h", i, got_beats[i], exp_beats[i]); end
        end
        checks += 6;
        if ((got_beats.size() > 0 ? got_beats[0] : 4'hx) !== 4'h0) begin errors++; $display("[TB] FAIL t1 beat0 value: expected 0"); end
        if ((got_beats.size() > 31 ? got_beats[31] : 4'hx) !== 4'hF) begin errors++; $display("[TB] FAIL t1 beat31 value: expected F"); end
        if ((got_cyc.size() > 0 ? got_cyc[0] : -1) != 4) begin errors++; $display("[TB] FAIL t1 first valid cycle: got %0d expected 4", got_cyc.size() > 0 ? got_cyc[0] : -1); end
        if ((got_cyc.size() > 31 ? got_cyc[31] : -1) != 35) begin errors++; $display("[TB] FAIL t1 last valid cycle: got %0d expected 35", got_cyc.size() > 31 ? got_cyc[31] : -1); end
        if (done_cyc.size() != 1 || done_cyc[0] != 36) begin errors++; $display("[TB] FAIL t1 done: got %0d pulses first at %0d expected 1 at 36", done_cyc.size(), done_cyc.size() > 0 ? done_cyc[0] : -1); end
        if (got_addrs.size() != 1 || got_addrs[0] != 0) begin errors++; $display("[TB] FAIL t1 addresses: got %0d distinct expected 1 (addr 0)", got_addrs.size()); end
    endtask

    task automatic test_back_to_back();
        int gaps;
        fill_random(100, 4);
        build_expected(100, 4);
        run_frame(100, 4, 1'b0, -1, -1);
        gaps = 0;
        for (int i = 0; i < got_cyc.size(); i++) if (got_cyc[i] != 4 + i) gaps++;
        checks += 4;
        if (got_beats.size() != 128) begin errors++; $display("[TB] FAIL t2 beat count: got %0d expected 128", got_beats.size()); end
        if (gaps != 0) begin errors++; $display("[TB] FAIL t2 bubbles: got %0d off-schedule beats expected 0", gaps); end
        if (done_cyc.size() != 1 || done_cyc[0] != 132) begin errors++; $display("[TB] FAIL t2 done: got %0d pulses first at %0d expected 1 at 132", done_cyc.size(), done_cyc.size() > 0 ? done_cyc[0] : -1); end
        if (got_addrs != exp_addrs) begin errors++; $display("[TB] FAIL t2 addresses: got %0d distinct expected 100..103", got_addrs.size()); end
        for (int i = 0; i < exp_beats.size() && i < got_beats.size(); i++) begin
            checks++;
            if (got_beats[i] !== exp_beats[i]) begin errors++; $display("[TB] FAIL t2 beat %0d: got %h expected %h", i, got_beats[i], exp_beats[i]); end
        end
    endtask

    task automatic test_random_ready();
        int base;
        base = $urandom_range(1000, 7000);
        fill_random(base, 3);
        build_expected(base, 3);
        run_frame(base, 3, 1'b1, -1, -1);
        checks += 4;
        if (got_beats.size() != 96) begin errors++; $display("[TB] FAIL t3 transfer count: got %0d expected 96", got_beats.size()); end
        if (stall_err != 0) begin errors++; $display("[TB] FAIL t3 stall stability: got %0d violations expected 0", stall_err); end
        if (done_cyc.size() != 1) begin errors++; $display("[TB] FAIL t3 done pulses: got %0d expected 1", done_cyc.size()); end
        if (timed_out) begin errors++; $display("[TB] FAIL t3 timeout: got no done expected done"); end
        for (int i = 0; i < exp_beats.size() && i < got_beats.size(); i++) begin
            checks++;
            if (got_beats[i] !== exp_beats[i]) begin errors++; $display("[TB] FAIL t3 beat %0d: got %h expected %h", i, got_beats[i], exp_beats[i]); end
        end
    endtask

    task automatic test_addr_wrap();
        fill_random(8190, 3);
        build_expected(8190, 3);
        run_frame(8190, 3, 1'b0, -1, -1);
        checks += 3;
        if (got_addrs != exp_addrs) begin
            errors++;
            $display("[TB] FAIL t4 addresses: got %0d distinct (last %0d) expected 8190,8191,0", got_addrs.size(), got_addrs.size() > 0 ? got_addrs[$] : -1);
        end
        if (got_beats.size() != 96) begin errors++; $display("[TB] FAIL t4 beat count: got %0d expected 96", got_beats.size()); end
        if (done_cyc.size() != 1) begin errors++; $display("[TB] FAIL t4 done pulses: got %0d expected 1", done_cyc.size()); end
        for (int i = 0; i < exp_beats.size() && i < got_beats.size(); i++) begin
            checks++;
            if (got_beats[i] !== exp_beats[i]) begin errors++; $display("[TB] FAIL t4 beat %0d: got %h expected %h", i, got_beats[i], exp_beats[i]); end
        end
    endtask

    task automatic test_zero_lines_and_busy_start();
        run_frame(50, 0, 1'b0, -1, -1);
        checks += 3;
        if (done_cyc.size() != 1 || done_cyc[0] != 1) begin errors++; $display("[TB] FAIL t5 zero-line done: got %0d pulses first at %0d expected 1 at 1", done_cyc.size(), done_cyc.size() > 0 ? done_cyc[0] : -1); end
        if (valid_seen != 0) begin errors++; $display("[TB] FAIL t5 zero-line valid: got %0d cycles expected 0", valid_seen); end
        if (got_addrs.size() != 0) begin errors++; $display("[TB] FAIL t5 zero-line busy: got %0d busy addresses expected 0", got_addrs.size()); end
        fill_random(200, 2);
        fill_random(500, 5);
        build_expected(200, 2);
        run_frame(200, 2, 1'b0, 10, -1);
        checks += 3;
        if (got_addrs != exp_addrs) begin errors++; $display("[TB] FAIL t5 restart addresses: got %0d distinct expected 200,201", got_addrs.size()); end
        if (got_beats.size() != 64) begin errors++; $display("[TB] FAIL t5 restart beat count: got %0d expected 64", got_beats.size()); end
        if (done_cyc.size() != 1 || done_cyc[0] != 68) begin errors++; $display("[TB] FAIL t5 restart done: got %0d pulses first at %0d expected 1 at 68", done_cyc.size(), done_cyc.size() > 0 ? done_cyc[0] : -1); end
        for (int i = 0; i < exp_beats.size() && i < got_beats.size(); i++) begin
            checks++;
            if (got_beats[i] !== exp_beats[i]) begin errors++; $display("[TB] FAIL t5 beat %0d: got %h expected %h", i, got_beats[i], exp_beats[i]); end
        end
    endtask

    task automatic test_reset_abort();
        fill_random(300, 2);
        post_rst = '1;
        run_frame(300, 2, 1'b0, -1, 10);
        checks += 2;
        if (post_rst !== '0) begin errors++; $display("[TB] FAIL t6 outputs after reset: got %h expected 0", post_rst); end
        if (done_cyc.size() != 0) begin errors++; $display("[TB] FAIL t6 done after abort: got %0d pulses expected 0", done_cyc.size()); end
        fill_random(300, 2);
        build_expected(300, 2);
        run_frame(300, 2, 1'b0, -1, -1);
        checks += 3;
        if (got_beats.size() != 64) begin errors++; $display("[TB] FAIL t6 fresh beat count: got %0d expected 64", got_beats.size()); end
        if ((got_cyc.size() > 0 ? got_cyc[0] : -1) != 4) begin errors++; $display("[TB] FAIL t6 fresh first valid: got %0d expected 4", got_cyc.size() > 0 ? got_cyc[0] : -1); end
        if (got_addrs != exp_addrs) begin errors++; $display("[TB] FAIL t6 fresh addresses: got %0d distinct expected 300,301", got_addrs.size()); end
        for (int i = 0; i < exp_beats.size() && i < got_beats.size(); i++) begin
            checks++;
            if (got_beats[i] !== exp_beats[i]) begin errors++; $display("[TB] FAIL t6 beat %0d: got %h expected %h", i, got_beats[i], exp_beats[i]); end
        end
    endtask

`ifdef SPIKES_READER_CNT_EN
    task automatic test_spike_count();
        int ones;
        mem[400] = '1;
        mem[401] = '1;
        build_expected(400, 2);
        ones = 0;
        foreach (exp_beats[i]) ones += $countones(exp_beats[i]);
        run_frame(400, 2, 1'b1, -1, -1);
        checks += 2;
        if (ones != 256) begin errors++; $display("[TB] FAIL cnt model: got %0d expected 256", ones); end
        if (o_spike_cnt !== 32'(ones)) begin errors++; $display("[TB] FAIL cnt value: got %0d expected %0d", o_spike_cnt, ones); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_line();
        test_back_to_back();
        test_random_ready();
        test_addr_wrap();
        test_zero_lines_and_busy_start();
        test_reset_abort();
`ifdef SPIKES_READER_CNT_EN
        test_spike_count();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
